// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and the
// default timing constants for a 100 MHz system clock.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DB_CYCLES   = 2_000_000;   // 20 ms @ 100 MHz
  localparam int unsigned DEF_LONG_CYCLES = 100_000_000; // 1 s @ 100 MHz

endpackage

// File: rtl/key_sync.sv
// Multi-stage synchroniser: STAGES flip-flops with asynchronous reset to 0.
module key_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_out
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_in};
    end
  end

  assign o_out = r_chain[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Push-button synchroniser + debouncer producing a clean pressed level.
// Optional long-press pulse enabled by defining KEY_DEBOUNCER_LONG_PRESS_EN.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic busy,
  output logic key_long
);

  localparam int unsigned     CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
    $error("key_debouncer: parameter out of range");
  end

  logic       w_k_raw;
  logic       w_k_s;
  db_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic       r_key_level;
  logic       r_busy;

  assign w_k_raw = key_in ^ ACTIVE_LOW;

  key_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_in    (w_k_raw),
    .o_out   (w_k_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_key_level <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_k_s) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_k_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == DB_LAST) begin
            r_state     <= ST_PRESSED;
            r_cnt       <= '0;
            r_key_level <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_k_s) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_k_s) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == DB_LAST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_key_level <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign key_level = r_key_level;
  assign busy      = r_busy;

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned     LP_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_CYCLES);

  logic            w_enter_idle;
  logic [LP_W-1:0] r_lp_cnt;
  logic            r_key_long;

  assign w_enter_idle = !w_k_s &&
                        ((r_state == ST_PRESS_WAIT) ||
                         (r_state == ST_RELEASE_WAIT && r_cnt == DB_LAST));

  // Saturating at LONG_CYCLES (one past the fire value) limits key_long to one pulse per press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lp_cnt   <= '0;
      r_key_long <= 1'b0;
    end else begin
      r_key_long <= 1'b0;
      if (w_enter_idle) begin
        r_lp_cnt <= '0;
      end else if (r_state == ST_PRESSED) begin
        if (r_lp_cnt == LP_LAST) begin
          r_lp_cnt   <= LP_SAT;
          r_key_long <= 1'b1;
        end else if (r_lp_cnt != LP_SAT) begin
          r_lp_cnt <= r_lp_cnt + LP_W'(1);
        end
      end
    end
  end

  assign key_long = r_key_long;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer (SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=8, active-low key).
module tb_key_debouncer;

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_in;
  logic key_level;
  logic busy;
  logic key_long;

  typedef struct {
    string      tag;
    logic [2:0] exp;   // {key_level, busy, key_long}
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  key_debouncer #(
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .LONG_CYCLES (8),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_level (key_level),
    .busy      (busy),
    .key_long  (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic pop_check();
    exp_t       e;
    logic [2:0] obs;
    obs = {key_level, busy, key_long};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got %b required an expectation entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: got lvl/busy/long=%b required %b", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive key for the coming edge, record expectation, compare 1 ns after the edge.
  task automatic cyc(input logic k, input logic [2:0] exp, input string tag);
    key_in = k;
    sb.push_back('{tag, exp});
    @(posedge sys_clk);
    #1;
    pop_check();
  endtask

  task automatic run(input logic k, input logic [2:0] exp, input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) cyc(k, exp, tag);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    #1;
    sb.push_back('{"reset_async", 3'b000});
    pop_check();
    run(1'b1, 3'b000, 2, "reset_held");
    sys_rst_n = 1'b1;
    run(1'b1, 3'b000, 3, "idle");

    // Clean press held 20+ cycles; long pulse 8 cycles after level rises
    run(1'b0, 3'b000, 2, "t1_sync");
    run(1'b0, 3'b010, 4, "t1_busy");
    cyc(1'b0, 3'b100, "t1_level");
    run(1'b0, 3'b100, 7, "t1_hold");
    cyc(1'b0, {1'b1, 1'b0, LP}, "t6_long");
    run(1'b0, 3'b100, 12, "t6_after");

    // Clean release
    run(1'b1, 3'b100, 2, "t4_sync");
    run(1'b1, 3'b110, 4, "t4_busy");
    cyc(1'b1, 3'b000, "t4_level");
    run(1'b1, 3'b000, 3, "t4_idle");

    // Bounce: low 3, high 2, low held
    run(1'b0, 3'b000, 2, "t2_sync");
    cyc(1'b0, 3'b010, "t2_pw");
    run(1'b1, 3'b010, 2, "t2_bounce");
    run(1'b0, 3'b000, 2, "t2_reject");
    run(1'b0, 3'b010, 4, "t2_retime");
    cyc(1'b0, 3'b100, "t2_level");
    run(1'b0, 3'b100, 2, "t2_hold");

    // Release glitch of 2 cycles; long counter holds while in release wait
    run(1'b1, 3'b100, 2, "t3_glitch");
    run(1'b0, 3'b110, 2, "t3_rwait");
    run(1'b0, 3'b100, 3, "t3_back");
    cyc(1'b0, {1'b1, 1'b0, LP}, "t3_long");
    run(1'b0, 3'b100, 2, "t3_hold");
    run(1'b1, 3'b100, 2, "t3r_sync");
    run(1'b1, 3'b110, 4, "t3r_busy");
    cyc(1'b1, 3'b000, "t3r_level");
    run(1'b1, 3'b000, 2, "t3r_idle");

    // Reset in PRESS_WAIT with cnt=2, key kept held
    run(1'b0, 3'b000, 2, "t5_sync");
    run(1'b0, 3'b010, 3, "t5_pw");
    sys_rst_n = 1'b0;
    #1;
    sb.push_back('{"t5_async", 3'b000});
    pop_check();
    cyc(1'b0, 3'b000, "t5_in_reset");
    sys_rst_n = 1'b1;
    run(1'b0, 3'b000, 2, "t5r_sync");
    run(1'b0, 3'b010, 4, "t5r_busy");
    cyc(1'b0, 3'b100, "t5r_level");
    run(1'b0, 3'b100, 2, "t5r_hold");

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: got %0d leftover entries required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
